// File: rtl/data_mem_responder_if.sv
// Purpose : datapath-to-data-memory request/response bundle.
// Latency : none; plain wires.
// Backpr. : the initiator holds MemRead/MemWrite until mem_ready pulses.
//
// master = datapath (drives the request), slave = memory responder.
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] memWriteData;
    logic [2:0]  funct3;
    logic [31:0] memReadData;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output MemRead, MemWrite, addr, memWriteData, funct3,
        input  memReadData, mem_ready, mem_err
    );

    modport slave (
        input  MemRead, MemWrite, addr, memWriteData, funct3,
        output memReadData, mem_ready, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : word-organised data RAM with byte-lane writes and extended loads.
// Latency : mem_ready pulses WAIT_CYCLES+1 cycles after the accepting edge.
// Backpr. : requests are held by the initiator; one access per WAIT_CYCLES+2 cycles.
//
// Ports: clk, rst (sync, active-low), bus (slave side of data_mem_responder_if:
// MemRead/MemWrite/addr/memWriteData/funct3 in, memReadData/mem_ready/mem_err out).
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    // 33 bits so that a full 4 GiB array would still compare correctly.
    localparam logic [32:0]      BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [1:0]       state;
    logic [CNT_W-1:0] waitCnt;
    logic [31:0]      capAddr;
    logic [31:0]      capData;
    logic [2:0]       capFunct3;
    logic             capRead;
    logic             capWrite;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            capRead  <= 1'b0;
            capWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MemRead || bus.MemWrite) begin
                        capAddr   <= bus.addr;
                        capData   <= bus.memWriteData;
                        capFunct3 <= bus.funct3;
                        capRead   <= bus.MemRead;
                        capWrite  <= bus.MemWrite;
                        waitCnt   <= '0;
                        state     <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (waitCnt == LAST_CNT) begin
                        waitCnt <= '0;
                        state   <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- decode of the captured access ----------------
    logic [31:0]      off;
    logic [IDX_W-1:0] wordIdx;
    logic             outOfRange;
    logic             misaligned;
    logic             badLoad;
    logic             badStore;
    logic             accessErr;

    // off wraps modulo 2^32, so addresses below ADDR_BASE land far above the limit.
    assign off        = capAddr - ADDR_BASE;
    assign wordIdx    = off[IDX_W+1:2];
    assign outOfRange = {1'b0, off} >= BYTE_LIMIT;
    assign misaligned = ((capFunct3[1:0] == 2'b01) && off[0]) ||
                        ((capFunct3[1:0] == 2'b10) && (off[1:0] != 2'b00));
    assign badLoad    = capRead && !(capFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign badStore   = capWrite && !(capFunct3 inside {3'b000, 3'b001, 3'b010});
    assign accessErr  = outOfRange || misaligned || badLoad || badStore || (capRead && capWrite);

    // ---------------- load path ----------------
    logic [31:0] rdWord;
    logic [31:0] laneSh;
    logic [31:0] loadVal;

    assign rdWord = mem[wordIdx];
    assign laneSh = rdWord >> {off[1:0], 3'b000};

    always_comb begin
        loadVal = '0;
        case (capFunct3)
            3'b000:  loadVal = {{24{laneSh[7]}},  laneSh[7:0]};
            3'b001:  loadVal = {{16{laneSh[15]}}, laneSh[15:0]};
            3'b010:  loadVal = rdWord;
            3'b100:  loadVal = {24'b0, laneSh[7:0]};
            3'b101:  loadVal = {16'b0, laneSh[15:0]};
            default: loadVal = '0;
        endcase
    end

    assign bus.mem_ready   = (state == RESP);
    assign bus.mem_err     = (state == RESP) && accessErr;
    assign bus.memReadData = ((state == RESP) && capRead && !accessErr) ? loadVal : 32'b0;

    // ---------------- store path ----------------
    logic        doWrite;
    logic [3:0]  byteEn;
    logic [31:0] wrWord;

    // A reset landing on the RESP edge aborts the store as well.
    assign doWrite = (state == RESP) && capWrite && !accessErr && rst;

    always_comb begin
        byteEn = 4'b0000;
        wrWord = capData;
        case (capFunct3[1:0])
            2'b00: begin
                byteEn = 4'b0001 << off[1:0];
                wrWord = {4{capData[7:0]}};
            end
            2'b01: begin
                byteEn = off[1] ? 4'b1100 : 4'b0011;
                wrWord = {2{capData[15:0]}};
            end
            2'b10: begin
                byteEn = 4'b1111;
                wrWord = capData;
            end
            default: begin
                byteEn = 4'b0000;
                wrWord = capData;
            end
        endcase
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
            end
        end
    end

endmodule
